// File: rtl/bus_dest_regs_pkg.sv
// Shared encodings for the bus write side: destination select codes
// and increment-request bit positions. Codes 0-8 match the source side.
package bus_dest_regs_pkg;

    // Destination select codes (writeSel)
    localparam logic [3:0] DMEM_SEL = 4'd0;
    localparam logic [3:0] R_SEL    = 4'd1;
    localparam logic [3:0] IR_SEL   = 4'd2;
    localparam logic [3:0] RL_SEL   = 4'd3;
    localparam logic [3:0] RC_SEL   = 4'd4;
    localparam logic [3:0] RP_SEL   = 4'd5;
    localparam logic [3:0] RQ_SEL   = 4'd6;
    localparam logic [3:0] R1_SEL   = 4'd7;
    localparam logic [3:0] AC_SEL   = 4'd8;
    localparam logic [3:0] IDLE_SEL = 4'd9;
    localparam logic [3:0] AR_SEL   = 4'd10;

    // Bit positions inside incSel
    localparam int INC_RC = 0;
    localparam int INC_RP = 1;
    localparam int INC_RQ = 2;

    // Codes above AR_SEL are unassigned and act as IDLE
    function automatic logic is_bad_code(input logic [3:0] sel);
        return (sel > AR_SEL);
    endfunction

endpackage

// File: rtl/bus_load_reg.sv
// Register with synchronous reset, bus load and +1 increment.
// A load in the same cycle as an increment stores the bus word unchanged.
module bus_load_reg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset beats load, load beats increment; increment wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/bus_dest_regs.sv
// Write side of the shared data bus: destination registers, DMEM strobe,
// counter increments, AC zero flag. Optional checker: BUS_DEST_CHECK_EN.
module bus_dest_regs
    import bus_dest_regs_pkg::*;
#(
    parameter int REG_WIDTH = 12,
    parameter int INS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           writeSel,
    input  logic [2:0]           incSel,
    input  logic [REG_WIDTH-1:0] busIn,
    output logic [REG_WIDTH-1:0] R,
    output logic [REG_WIDTH-1:0] RL,
    output logic [REG_WIDTH-1:0] RC,
    output logic [REG_WIDTH-1:0] RP,
    output logic [REG_WIDTH-1:0] RQ,
    output logic [REG_WIDTH-1:0] R1,
    output logic [REG_WIDTH-1:0] AC,
    output logic [REG_WIDTH-1:0] AR,
    output logic [INS_WIDTH-1:0] IR,
    output logic                 zFlag,
    output logic                 DMemWrEn,
    output logic [REG_WIDTH-1:0] DMemAddr,
    output logic [REG_WIDTH-1:0] DMemWrData,
    output logic                 errFlag
);

    logic ld_r;
    logic ld_ir;
    logic ld_rl;
    logic ld_rc;
    logic ld_rp;
    logic ld_rq;
    logic ld_r1;
    logic ld_ac;
    logic ld_ar;
    logic ld_dmem;

    // One-hot destination decode; idle and unassigned codes select nothing
    always_comb begin
        ld_r    = 1'b0;
        ld_ir   = 1'b0;
        ld_rl   = 1'b0;
        ld_rc   = 1'b0;
        ld_rp   = 1'b0;
        ld_rq   = 1'b0;
        ld_r1   = 1'b0;
        ld_ac   = 1'b0;
        ld_ar   = 1'b0;
        ld_dmem = 1'b0;
        case (writeSel)
            DMEM_SEL: ld_dmem = 1'b1;
            R_SEL:    ld_r    = 1'b1;
            IR_SEL:   ld_ir   = 1'b1;
            RL_SEL:   ld_rl   = 1'b1;
            RC_SEL:   ld_rc   = 1'b1;
            RP_SEL:   ld_rp   = 1'b1;
            RQ_SEL:   ld_rq   = 1'b1;
            R1_SEL:   ld_r1   = 1'b1;
            AC_SEL:   ld_ac   = 1'b1;
            AR_SEL:   ld_ar   = 1'b1;
            default:  ;
        endcase
    end

    bus_load_reg #(.WIDTH(REG_WIDTH)) u_r (
        .clk  (clk),
        .rst  (rst),
        .load (ld_r),
        .inc  (1'b0),
        .d    (busIn),
        .q    (R)
    );

    bus_load_reg #(.WIDTH(INS_WIDTH)) u_ir (
        .clk  (clk),
        .rst  (rst),
        .load (ld_ir),
        .inc  (1'b0),
        .d    (busIn[INS_WIDTH-1:0]),
        .q    (IR)
    );

    bus_load_reg #(.WIDTH(REG_WIDTH)) u_rl (
        .clk  (clk),
        .rst  (rst),
        .load (ld_rl),
        .inc  (1'b0),
        .d    (busIn),
        .q    (RL)
    );

    bus_load_reg #(.WIDTH(REG_WIDTH)) u_rc (
        .clk  (clk),
        .rst  (rst),
        .load (ld_rc),
        .inc  (incSel[INC_RC]),
        .d    (busIn),
        .q    (RC)
    );

    bus_load_reg #(.WIDTH(REG_WIDTH)) u_rp (
        .clk  (clk),
        .rst  (rst),
        .load (ld_rp),
        .inc  (incSel[INC_RP]),
        .d    (busIn),
        .q    (RP)
    );

    bus_load_reg #(.WIDTH(REG_WIDTH)) u_rq (
        .clk  (clk),
        .rst  (rst),
        .load (ld_rq),
        .inc  (incSel[INC_RQ]),
        .d    (busIn),
        .q    (RQ)
    );

    bus_load_reg #(.WIDTH(REG_WIDTH)) u_r1 (
        .clk  (clk),
        .rst  (rst),
        .load (ld_r1),
        .inc  (1'b0),
        .d    (busIn),
        .q    (R1)
    );

    bus_load_reg #(.WIDTH(REG_WIDTH)) u_ac (
        .clk  (clk),
        .rst  (rst),
        .load (ld_ac),
        .inc  (1'b0),
        .d    (busIn),
        .q    (AC)
    );

    bus_load_reg #(.WIDTH(REG_WIDTH)) u_ar (
        .clk  (clk),
        .rst  (rst),
        .load (ld_ar),
        .inc  (1'b0),
        .d    (busIn),
        .q    (AR)
    );

    // Zero flag tracks the word written into AC, holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            zFlag <= 1'b1;
        end else if (ld_ac) begin
            zFlag <= (busIn == '0);
        end
    end

    // Memory write strobe lasts one cycle per sampled DMEM code
    always_ff @(posedge clk) begin
        if (rst) begin
            DMemWrEn   <= 1'b0;
            DMemWrData <= '0;
        end else begin
            DMemWrEn <= ld_dmem;
            if (ld_dmem) begin
                DMemWrData <= busIn;
            end
        end
    end

    assign DMemAddr = AR;

`ifdef BUS_DEST_CHECK_EN
    logic bad_code;
    logic inc_clash;
    logic err_q;

    assign bad_code  = is_bad_code(writeSel);
    assign inc_clash = (incSel[INC_RC] & ld_rc)
                     | (incSel[INC_RP] & ld_rp)
                     | (incSel[INC_RQ] & ld_rq);

    // Sticky error: unassigned code or load/increment collision
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad_code | inc_clash) begin
            err_q <= 1'b1;
        end
    end

    assign errFlag = err_q;
`else
    assign errFlag = 1'b0;
`endif

endmodule
